// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: one read/write port plus one read port, byte-masked writes, 1-cycle read latency.
// Define SRAM_WR_FWD_EN so that an R read colliding with an RW write returns the post-write word.
module sram_1rw1r_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rw_valid,
  input  logic              rw_w_en,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [MASK_W-1:0] rw_wmask,
  input  logic [DATA_W-1:0] rw_data_in,
  output logic [DATA_W-1:0] rw_data_out,
  output logic              rw_rvalid,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data_out,
  output logic              r_rvalid,
  output logic              collision,
  output logic              addr_err
);
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rw_old, r_old, wr_word, r_word;
  logic rw_in, r_in, rw_wr, rw_rd, hit;
  assign rw_in = {1'b0, rw_addr} < LIMIT;
  assign r_in = {1'b0, r_addr} < LIMIT;
  assign rw_wr = rw_valid & rw_w_en;
  assign rw_rd = rw_valid & ~rw_w_en;
  assign rw_old = mem[rw_addr];
  assign r_old = mem[r_addr];
  assign hit = rw_wr & r_valid & rw_in & (rw_addr == r_addr);
  for (genvar i = 0; i < MASK_W; i++) begin : g_lane
    assign wr_word[8*i +: 8] = rw_wmask[i] ? rw_data_in[8*i +: 8] : rw_old[8*i +: 8];
  end
`ifdef SRAM_WR_FWD_EN
  assign r_word = hit ? wr_word : r_old;
`else
  assign r_word = r_old;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rw_data_out <= '0;
      r_data_out <= '0;
      rw_rvalid <= 1'b0;
      r_rvalid <= 1'b0;
      collision <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rw_rvalid <= rw_rd;
      r_rvalid <= r_valid;
      collision <= hit;
      addr_err <= (rw_valid & ~rw_in) | (r_valid & ~r_in);
      if (rw_rd) rw_data_out <= rw_in ? rw_old : '0;
      if (r_valid) r_data_out <= r_in ? r_word : '0;
    end
  // Contents are never reset; requests seen while in reset are dropped.
  always_ff @(posedge clk or negedge rst_n)
    if (rst_n && rw_wr && rw_in) mem[rw_addr] <= wr_word;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: directed stimulus, array-based reference model checked every cycle.
module tb_sram_1rw1r_param;
  localparam int DEPTH = 1000;
  logic clk = 0;
  logic rst_n = 0;
  logic rw_valid = 0, rw_w_en = 0, r_valid = 0;
  logic [9:0] rw_addr = 0, r_addr = 0;
  logic [1:0] rw_wmask = 0;
  logic [15:0] rw_data_in = 0;
  logic [15:0] rw_data_out, r_data_out;
  logic rw_rvalid, r_rvalid, collision, addr_err;
  int checks = 0, errors = 0;
  logic [15:0] mm [1024];
  logic [15:0] e_rwd = 0, e_rd = 0;
  logic e_rwv = 0, e_rv = 0, e_col = 0, e_err = 0;

  sram_1rw1r_param #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rw_valid(rw_valid), .rw_w_en(rw_w_en), .rw_addr(rw_addr),
    .rw_wmask(rw_wmask), .rw_data_in(rw_data_in), .rw_data_out(rw_data_out), .rw_rvalid(rw_rvalid),
    .r_valid(r_valid), .r_addr(r_addr), .r_data_out(r_data_out), .r_rvalid(r_rvalid),
    .collision(collision), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] f(input int a);
    return 16'(a * 73 + 'h1111);
  endfunction

  // Reference model: memory array plus the rules for what each output shows next cycle.
  always @(negedge rst_n) begin
    e_rwd = 0; e_rd = 0; e_rwv = 0; e_rv = 0; e_col = 0; e_err = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      e_rwd = 0; e_rd = 0; e_rwv = 0; e_rv = 0; e_col = 0; e_err = 0;
    end else begin
      logic [15:0] nw;
      e_rwv = rw_valid && !rw_w_en;
      e_rv = r_valid;
      e_col = 0;
      e_err = (rw_valid && rw_addr >= DEPTH) || (r_valid && r_addr >= DEPTH);
      if (e_rwv) e_rwd = (rw_addr < DEPTH) ? mm[rw_addr] : 16'h0;
      if (r_valid) e_rd = (r_addr < DEPTH) ? mm[r_addr] : 16'h0;
      if (rw_valid && rw_w_en && rw_addr < DEPTH) begin
        nw = mm[rw_addr];
        for (int b = 0; b < 2; b++) if (rw_wmask[b]) nw[8*b +: 8] = rw_data_in[8*b +: 8];
        mm[rw_addr] = nw;
        if (r_valid && r_addr == rw_addr) begin
          e_col = 1;
`ifdef SRAM_WR_FWD_EN
          e_rd = nw;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rw_data_out", rw_data_out, e_rwd);
    chk("r_data_out", r_data_out, e_rd);
    chk("rw_rvalid", 16'(rw_rvalid), 16'(e_rwv));
    chk("r_rvalid", 16'(r_rvalid), 16'(e_rv));
    chk("collision", 16'(collision), 16'(e_col));
    chk("addr_err", 16'(addr_err), 16'(e_err));
  end

  task automatic cyc(input logic v, input logic we, input logic [9:0] a, input logic [1:0] m,
                     input logic [15:0] d, input logic rv, input logic [9:0] ra);
    rw_valid = v; rw_w_en = we; rw_addr = a; rw_wmask = m; rw_data_in = d;
    r_valid = rv; r_addr = ra;
    @(negedge clk);
    rw_valid = 0; r_valid = 0; rw_w_en = 0;
  endtask

  initial begin
    int n_rw, n_r;
    repeat (3) @(negedge clk);
    chk("reset_rw_data", rw_data_out, 16'h0);
    chk("reset_rvalid", 16'(r_rvalid), 16'h0);
    rst_n = 1;
    for (int a = 0; a < DEPTH; a++) cyc(1, 1, 10'(a), 2'b11, f(a), 0, 0);
    cyc(1, 1, 5, 2'b11, 16'hA5C3, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5);
    chk("req034_data", r_data_out, 16'hA5C3);
    chk("req034_rvalid", 16'(r_rvalid), 16'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold_rvalid", 16'(r_rvalid), 16'h0);
    chk("hold_data", r_data_out, 16'hA5C3);
    cyc(1, 1, 7, 2'b11, 16'h1234, 0, 0);
    cyc(1, 1, 7, 2'b10, 16'hFFFF, 0, 0);
    chk("write_no_rvalid", 16'(rw_rvalid), 16'h0);
    cyc(1, 0, 7, 0, 0, 0, 0);
    chk("req035_data", rw_data_out, 16'hFF34);
    cyc(1, 1, 7, 2'b00, 16'h0000, 0, 0);
    chk("write_keeps_out", rw_data_out, 16'hFF34);
    cyc(1, 0, 7, 0, 0, 0, 0);
    chk("mask0_unchanged", rw_data_out, 16'hFF34);
    cyc(1, 1, 9, 2'b11, 16'h0000, 0, 0);
    cyc(1, 1, 9, 2'b01, 16'hBEEF, 1, 9);
    chk("req036_collision", 16'(collision), 16'h1);
`ifdef SRAM_WR_FWD_EN
    chk("req036_data", r_data_out, 16'h00EF);
`else
    chk("req036_data", r_data_out, 16'h0000);
`endif
    cyc(0, 0, 0, 0, 0, 1, 9);
    chk("collision_pulse", 16'(collision), 16'h0);
    chk("after_collision", r_data_out, 16'h00EF);
    cyc(1, 1, 1000, 2'b11, 16'h5555, 0, 0);
    chk("req037_werr", 16'(addr_err), 16'h1);
    cyc(1, 0, 1000, 0, 0, 1, 1020);
    chk("req037_rerr", 16'(addr_err), 16'h1);
    chk("req037_rw_zero", rw_data_out, 16'h0);
    chk("req037_r_zero", r_data_out, 16'h0);
    chk("req037_rvalid", 16'(rw_rvalid), 16'h1);
    for (int a = 0; a < DEPTH; a++) cyc(1, 0, 10'(a), 0, 0, 1, 10'(DEPTH - 1 - a));
    chk("sweep_last_rw", rw_data_out, f(999));
    chk("sweep_last_r", r_data_out, f(0));
    rw_valid = 1; rw_w_en = 1; rw_addr = 3; rw_wmask = 2'b11; rw_data_in = 16'hDEAD;
    r_valid = 1; r_addr = 3;
    #2 rst_n = 0;
    #1;
    chk("async_rw_zero", rw_data_out, 16'h0);
    chk("async_r_zero", r_data_out, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rw_valid = 0; r_valid = 0; rw_w_en = 0;
    chk("in_reset_rvalid", 16'(r_rvalid), 16'h0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("release_rvalid", 16'(r_rvalid), 16'h0);
    cyc(0, 0, 0, 0, 0, 1, 3);
    chk("req038_survive", r_data_out, 16'h11EC);
    n_rw = 0; n_r = 0;
    for (int a = 0; a < 16; a++) begin
      cyc(1, 0, 10'(a), 0, 0, 1, 10'(a));
      n_rw += int'(rw_rvalid);
      n_r += int'(r_rvalid);
    end
    chk("req039_rw_count", 16'(n_rw), 16'd16);
    chk("req039_r_count", 16'(n_r), 16'd16);
    chk("req039_last", r_data_out, f(15));
    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_param.md
SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; multiple of 8.
REQ-002 Parameter DEPTH, default 1024: words per array; need not be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 Derived MASK_W = DATA_W/8: one write-enable bit per byte lane.
REQ-005 clk  in  1  single clock, all activity on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rw_valid  in  1  RW port request strobe.
REQ-008 rw_w_en  in  1  1 = write, 0 = read; sampled only when rw_valid = 1.
REQ-009 rw_addr  in  ADDR_W  RW port address.
REQ-010 rw_wmask  in  MASK_W  byte-lane write enables; bit i covers data bits [8i+7:8i].
REQ-011 rw_data_in  in  DATA_W  write data.
REQ-012 rw_data_out  out  DATA_W  RW port read data, registered.
REQ-013 rw_rvalid  out  1  rw_data_out carries a fresh read result this cycle.
REQ-014 r_valid  in  1  R port read request strobe.
REQ-015 r_addr  in  ADDR_W  R port address.
REQ-016 r_data_out  out  DATA_W  R port read data, registered.
REQ-017 r_rvalid  out  1  r_data_out carries a fresh read result this cycle.
REQ-018 collision  out  1  one-cycle pulse: same-cycle RW write and R read to the same in-range address.
REQ-019 addr_err  out  1  one-cycle pulse: an accepted request had an address >= DEPTH.

Function
REQ-020 Storage SHALL be DEPTH x DATA_W, behavioural; no contents reset.
REQ-021 A read on either port SHALL return data on rw_data_out/r_data_out in the cycle after the request, with rw_rvalid/r_rvalid high for exactly that cycle.
REQ-022 Data outputs SHALL hold their last value when no read completes; rvalid SHALL be 0 then.
REQ-023 A write (rw_valid=1, rw_w_en=1) SHALL update only the byte lanes with rw_wmask bit 1; rw_wmask = 0 SHALL leave the word unchanged.
REQ-024 A write SHALL NOT assert rw_rvalid and SHALL NOT change rw_data_out.
REQ-025 Requests with address >= DEPTH SHALL NOT modify memory; an out-of-range read SHALL return all zeros with rvalid = 1; addr_err SHALL pulse in the following cycle.
REQ-026 The same address on both ports, both reads, SHALL return identical data on both outputs.
REQ-027 An RW write and an R read to the same in-range address in the same cycle SHALL pulse collision in the following cycle; the R data is set by REQ-033.
REQ-028 Each port SHALL accept a new request every cycle (full throughput, no back-pressure).

Reset
REQ-029 While rst_n = 0: rw_data_out, r_data_out = 0; rw_rvalid, r_rvalid, collision, addr_err = 0.
REQ-030 Asserting rst_n SHALL take effect immediately, without waiting for clk; a read in flight SHALL be discarded (no rvalid after release).
REQ-031 Requests presented while rst_n = 0 SHALL be ignored, including writes.
REQ-032 Memory contents SHALL survive reset.

Configuration
REQ-033 Macro SRAM_WR_FWD_EN: when defined, an R read that collides with an RW write SHALL return the post-write word (masked lanes new, others old); when undefined, it SHALL return the pre-write word; collision pulses in both builds.

Verification
REQ-034 Write 0xA5C3 to addr 5 with mask 2'b11, read addr 5 on R next cycle -> r_data_out = 0xA5C3, r_rvalid = 1 one cycle after request.
REQ-035 Addr 7 holds 0x1234; write 0xFFFF with mask 2'b10; read on RW -> rw_data_out = 0xFF34.
REQ-036 Addr 9 holds 0x0000; same cycle RW write 0xBEEF mask 2'b01 and R read addr 9 -> collision = 1; r_data_out = 0x00EF with SRAM_WR_FWD_EN, 0x0000 without.
REQ-037 DEPTH = 1000: write 0x5555 to addr 1000, then read addr 1000 -> addr_err pulses for each request; read returns 0x0000; addr 0..999 unchanged.
REQ-038 Issue R read of addr 3 and assert rst_n = 0 before the next edge -> r_rvalid stays 0, all outputs 0 through release; addr 3 contents unchanged after reset.
REQ-039 Back-to-back reads of addrs 0..15 on both ports every cycle -> 16 consecutive rvalid pulses per port, data in request order.
